// File: rtl/ud_count_monitor.sv
// Watches a 4-bit up/down counter: counts wraps, flags direction changes and illegal steps.
// Optional hold/stall detector is built only when UD_MON_STALL_DET_EN is defined.
module ud_count_monitor #(
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       UpOrDown,
    input  logic [3:0] Count,
    input  logic       clr,
    output logic [7:0] wrap_up_cnt,
    output logic [7:0] wrap_dn_cnt,
    output logic       wrap_pulse,
    output logic       dir_chg,
    output logic       step_err,
    output logic       stall
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] prev_cnt_q;
    logic       prev_dir_q;
    logic [7:0] wrap_up_q, wrap_up_d;
    logic [7:0] wrap_dn_q, wrap_dn_d;
    logic       wrap_pulse_q, wrap_pulse_d;
    logic       dir_chg_q, dir_chg_d;
    logic       step_err_q, step_err_d;

    logic [3:0] cnt_inc_s;
    logic [3:0] cnt_dec_s;
    logic       is_hold_s;
    logic       up_step_s;
    logic       dn_step_s;
    logic       step_legal_s;
    logic       up_wrap_s;
    logic       dn_wrap_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Step classification of the current Count against last edge's sample.
    always_comb begin
        cnt_inc_s    = prev_cnt_q + 4'd1;
        cnt_dec_s    = prev_cnt_q - 4'd1;
        is_hold_s    = (Count == prev_cnt_q);
        up_step_s    = prev_dir_q && (Count == cnt_inc_s);
        dn_step_s    = !prev_dir_q && (Count == cnt_dec_s);
        step_legal_s = is_hold_s || up_step_s || dn_step_s;
        up_wrap_s    = up_step_s && (prev_cnt_q == 4'hF);
        dn_wrap_s    = dn_step_s && (prev_cnt_q == 4'h0);
    end

    // Next-state and statistics update; clr overrides every event.
    always_comb begin
        state_d      = state_q;
        wrap_up_d    = wrap_up_q;
        wrap_dn_d    = wrap_dn_q;
        wrap_pulse_d = 1'b0;
        dir_chg_d    = 1'b0;
        step_err_d   = step_err_q;
        if (clr) begin
            state_d    = ST_INIT;
            wrap_up_d  = 8'd0;
            wrap_dn_d  = 8'd0;
            step_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    dir_chg_d = (UpOrDown != prev_dir_q);
                    if (!step_legal_s) begin
                        step_err_d = 1'b1;
                        state_d    = ST_FAULT;
                    end else if (up_wrap_s) begin
                        wrap_up_d    = sat_inc8(wrap_up_q);
                        wrap_pulse_d = 1'b1;
                    end else if (dn_wrap_s) begin
                        wrap_dn_d    = sat_inc8(wrap_dn_q);
                        wrap_pulse_d = 1'b1;
                    end else begin
                        wrap_pulse_d = 1'b0;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // Main state, sample and output registers.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            prev_cnt_q   <= 4'd0;
            prev_dir_q   <= 1'b0;
            wrap_up_q    <= 8'd0;
            wrap_dn_q    <= 8'd0;
            wrap_pulse_q <= 1'b0;
            dir_chg_q    <= 1'b0;
            step_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_cnt_q   <= Count;
            prev_dir_q   <= UpOrDown;
            wrap_up_q    <= wrap_up_d;
            wrap_dn_q    <= wrap_dn_d;
            wrap_pulse_q <= wrap_pulse_d;
            dir_chg_q    <= dir_chg_d;
            step_err_q   <= step_err_d;
        end
    end

    assign wrap_up_cnt = wrap_up_q;
    assign wrap_dn_cnt = wrap_dn_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign dir_chg     = dir_chg_q;
    assign step_err    = step_err_q;

`ifdef UD_MON_STALL_DET_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       stall_q, stall_d;

    // Hold-run counter; only legal holds while tracking extend the run.
    always_comb begin
        hold_cnt_d = 8'd0;
        stall_d    = 1'b0;
        if (!clr && (state_q == ST_TRACK) && is_hold_s) begin
            hold_cnt_d = sat_inc8(hold_cnt_q);
            stall_d    = (hold_cnt_d >= STALL_LIMIT[7:0]);
        end else begin
            hold_cnt_d = 8'd0;
            stall_d    = 1'b0;
        end
    end

    // Stall detector registers.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= 8'd0;
            stall_q    <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

endmodule
